// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide engine sitting beside the single-cycle ALU
//   in the EX stage. One request is accepted through a valid/ready handshake,
//   the engine retires one bit per cycle (shift-add multiply or restoring
//   divide) and returns the result with a one-cycle o_valid pulse. The hazard
//   unit stalls the pipeline while o_busy is high.
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset
//   i_flush      abort the in-flight operation (no result is returned)
//   i_valid      request valid, accepted only while o_ready is high
//   i_md_op      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   i_operand_a  rs1 (multiplicand / dividend)
//   i_operand_b  rs2 (multiplier / divisor)
//   o_ready      high in IDLE only
//   o_busy       high from the cycle after acceptance through DONE
//   o_valid      one-cycle result strobe
//   o_md_data    result; holds its value until the next DONE
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [2:0]       i_md_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_md_data
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   data_q, data_d;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful on the accept edge)
  // ---------------------------------------------------------------------------
  logic             a_signed, b_signed, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf;

  assign a_signed = (i_md_op == 3'b001) || (i_md_op == 3'b010) ||
                    (i_md_op == 3'b100) || (i_md_op == 3'b110);
  assign b_signed = (i_md_op == 3'b001) || (i_md_op == 3'b100) ||
                    (i_md_op == 3'b110);
  assign sa       = a_signed & i_operand_a[WIDTH-1];
  assign sb       = b_signed & i_operand_b[WIDTH-1];
  assign mag_a    = sa ? -i_operand_a : i_operand_a;
  assign mag_b    = sb ? -i_operand_b : i_operand_b;
  assign div_zero = (i_operand_b == '0);
  // Only the signed divide ops (funct3[0]=0) can overflow: most-negative / -1.
  assign div_ovf  = !i_md_op[0] &&
                    (i_operand_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (i_operand_b == '1);

  // ---------------------------------------------------------------------------
  // One iteration of each datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_full;
  logic [WIDTH-1:0]   mul_res;

  // The add carries into bit WIDTH, which becomes the MSB after the shift.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  // Sign is applied to the full double-width product before selecting a half.
  assign mul_full = neg_q ? -mul_next : mul_next;
  assign mul_res  = (op_q[1:0] == 2'b00) ? mul_full[WIDTH-1:0]
                                         : mul_full[2*WIDTH-1:WIDTH];

  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_quo, div_rem, div_res;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = !div_diff[WIDTH];
  assign div_next  = {div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                      acc_q[WIDTH-2:0], div_ge};
  assign div_quo   = div_next[WIDTH-1:0];
  assign div_rem   = div_next[2*WIDTH-1:WIDTH];
  assign div_res   = op_q[1] ? (neg_q ? -div_rem : div_rem)
                             : (neg_q ? -div_quo : div_quo);

  logic last_iter;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    data_d  = data_q;

    if (i_flush) begin
      // Abandon everything; o_md_data keeps its previous result.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            op_d  = i_md_op;
            cnt_d = '0;
            // Remainder takes the dividend sign; product/quotient take sa^sb.
            neg_d = (i_md_op[2] && i_md_op[1]) ? sa : (sa ^ sb);
            if (!i_md_op[2]) begin
              acc_d   = {{WIDTH{1'b0}}, mag_b};
              opnd_d  = mag_a;
              state_d = S_MUL;
            end else if (div_zero) begin
              data_d  = i_md_op[1] ? i_operand_a : '1;
              state_d = S_DONE;
            end else if (div_ovf) begin
              data_d  = i_md_op[1] ? '0 : i_operand_a;
              state_d = S_DONE;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              opnd_d  = mag_b;
              state_d = S_DIV;
            end
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q + CW'(1);
          if (last_iter) begin
            cnt_d   = '0;
            data_d  = mul_res;
            state_d = S_DONE;
          end
        end
        S_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q + CW'(1);
          if (last_iter) begin
            cnt_d   = '0;
            data_d  = div_res;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      data_q  <= data_d;
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_busy    = (state_q != S_IDLE);
  assign o_valid   = (state_q == S_DONE);
  assign o_md_data = data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed vectors with hand-computed results. Each issued operation pushes
//   its expected data and expected result cycle into a scoreboard queue; an
//   independent monitor pops and compares whenever o_valid is seen.
//   Cycle numbering: the accept edge is edge 0, cycle n follows edge n-1.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W       = 32;
  localparam int LAT_RUN = W + 1;
  localparam int LAT_SPC = 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_flush;
  logic         i_valid;
  logic [2:0]   i_md_op;
  logic [W-1:0] i_operand_a;
  logic [W-1:0] i_operand_b;
  logic         o_ready;
  logic         o_busy;
  logic         o_valid;
  logic [W-1:0] o_md_data;

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .i_md_op     (i_md_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .o_ready     (o_ready),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_md_data   (o_md_data)
  );

  always #5 i_clk = ~i_clk;

  int edge_cnt = 0;
  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    string        name;
    logic [W-1:0] data;
    int           edge_at;  // edge_cnt value seen during the o_valid cycle
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got o_valid=1 data 0x%08h expected no result",
                 o_md_data);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_data"}, o_md_data, mon_e.data);
        check({mon_e.name, "_cycle"}, W'(edge_cnt), W'(mon_e.edge_at));
      end
    end
  end

  // Waits (bounded) at falling edges until the unit can accept.
  task automatic wait_ready();
    int n = 0;
    @(negedge i_clk);
    while (o_ready !== 1'b1 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", W'(o_ready), W'(1));
  endtask

  // Drives one request for one cycle; returns the index of its accept edge.
  // Operands are scrambled right after acceptance.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int acc_edge);
    wait_ready();
    i_valid     = 1'b1;
    i_md_op     = op;
    i_operand_a = a;
    i_operand_b = b;
    acc_edge    = edge_cnt + 1;
    @(negedge i_clk);
    i_valid     = 1'b0;
    i_md_op     = 3'($urandom);
    i_operand_a = $urandom;
    i_operand_b = $urandom;
  endtask

  // Waits (bounded) until the monitor has consumed every expected result.
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    if (n >= 100) check("drain_timeout", W'(sb.size()), W'(0));
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int lat);
    exp_t e;
    int   acc;
    e.name    = name;
    e.data    = exp;
    e.edge_at = edge_cnt + 1 + lat - 1;  // provisional, fixed below
    sb.push_back(e);
    issue(op, a, b, acc);
    // Request is driven at the falling edge after wait_ready, so the accept
    // edge is only known inside issue(); patch the queued entry.
    sb[sb.size()-1].edge_at = acc + lat - 1;
    drain();
  endtask

  task automatic wait_cycle(input int acc, input int n);
    while (edge_cnt < acc + n - 1) @(negedge i_clk);
  endtask

  initial begin
    exp_t e;
    int   acc;

    i_reset     = 1'b1;
    i_flush     = 1'b0;
    i_valid     = 1'b0;
    i_md_op     = '0;
    i_operand_a = '0;
    i_operand_b = '0;
    repeat (2) @(negedge i_clk);
    check("rst_ready", W'(o_ready), W'(1));
    check("rst_busy",  W'(o_busy),  W'(0));
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_data",  o_md_data,   '0);
    i_reset = 1'b0;

    // MUL with cycle-accurate handshake checks and an ignored request mid-run.
    e.name = "mul_7_neg3"; e.data = 32'hFFFF_FFEB; e.edge_at = 0;
    sb.push_back(e);
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, acc);
    sb[sb.size()-1].edge_at = acc + LAT_RUN - 1;
    wait_cycle(acc, 1);
    check("mul_c1_busy",  W'(o_busy),  W'(1));
    check("mul_c1_ready", W'(o_ready), W'(0));
    wait_cycle(acc, 5);
    i_valid = 1'b1; i_md_op = OP_DIVU; i_operand_a = 32'd100; i_operand_b = 32'd7;
    @(negedge i_clk);
    i_valid = 1'b0;
    wait_cycle(acc, 33);
    check("mul_c33_valid", W'(o_valid), W'(1));
    check("mul_c33_busy",  W'(o_busy),  W'(1));
    wait_cycle(acc, 34);
    check("mul_c34_ready", W'(o_ready), W'(1));
    check("mul_c34_busy",  W'(o_busy),  W'(0));
    check("mul_c34_valid", W'(o_valid), W'(0));

    // Back-to-back from here on: each run_op issues as soon as o_ready rises.
    run_op("mulh_min_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_RUN);
    run_op("mulhu_max_max", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_RUN);
    run_op("mulhsu_m1_2",   OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_RUN);
    run_op("div_m7_2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_RUN);
    run_op("rem_m7_2",      OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_RUN);
    run_op("divu_100_7",    OP_DIVU,   32'd100,       32'd7,         32'd14,        LAT_RUN);
    run_op("remu_100_7",    OP_REMU,   32'd100,       32'd7,         32'd2,         LAT_RUN);
    run_op("divu_5_0",      OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPC);
    run_op("rem_5_0",       OP_REM,    32'd5,         32'd0,         32'd5,         LAT_SPC);
    run_op("div_ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPC);
    run_op("rem_ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPC);

    // Flush mid-multiply: back to IDLE, no result, data unchanged.
    issue(OP_MUL, 32'd3, 32'd5, acc);
    wait_cycle(acc, 10);
    i_flush = 1'b1;
    wait_cycle(acc, 11);
    i_flush = 1'b0;
    check("flush_ready", W'(o_ready), W'(1));
    check("flush_busy",  W'(o_busy),  W'(0));
    check("flush_data",  o_md_data,   32'd0);

    // Flush coinciding with DONE: result still pulses.
    e.name = "flush_in_done"; e.data = 32'hFFFF_FFFF; e.edge_at = 0;
    sb.push_back(e);
    issue(OP_DIVU, 32'd9, 32'd0, acc);
    sb[sb.size()-1].edge_at = acc + LAT_SPC - 1;
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush_done_ready", W'(o_ready), W'(1));
    drain();

    // Flush in IDLE together with a request: the request is dropped.
    wait_ready();
    i_valid = 1'b1; i_flush = 1'b1;
    i_md_op = OP_MUL; i_operand_a = 32'd6; i_operand_b = 32'd6;
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_idle_busy", W'(o_busy),  W'(0));
    check("flush_idle_data", o_md_data,   32'hFFFF_FFFF);

    // Reset mid-divide, then a fresh multiply.
    issue(OP_DIVU, 32'd100, 32'd7, acc);
    wait_cycle(acc, 20);
    i_reset = 1'b1;
    wait_cycle(acc, 21);
    i_reset = 1'b0;
    check("rst2_ready", W'(o_ready), W'(1));
    check("rst2_busy",  W'(o_busy),  W'(0));
    check("rst2_valid", W'(o_valid), W'(0));
    check("rst2_data",  o_md_data,   '0);
    run_op("mul_3_4", OP_MUL, 32'd3, 32'd4, 32'd12, LAT_RUN);

    // Quiet period: any stray o_valid is flagged by the monitor.
    repeat (40) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
